// File: rtl/button_event_decoder_pkg.sv
//------------------------------------------------------------------------------
// Module  : button_event_decoder_pkg
// Purpose : Shared I/O front-end definitions. Holds the button event decoder
//           state encoding and the debouncer counter-width constant, plus a
//           small helper used to size hold counters.
// Ports   : none (package)
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package button_event_decoder_pkg;

  // Counter width used by the per-button sync_debounce block.
  localparam int unsigned C_DEBOUNCE_CNT_W = 20;

  // Button event decoder states. INIT is the reset state; LOCKOUT absorbs a
  // button that was already down when reset was released.
  typedef enum logic [2:0] {
    BTN_INIT    = 3'd0,
    BTN_IDLE    = 3'd1,
    BTN_PRESSED = 3'd2,
    BTN_LOCKOUT = 3'd3,
    BTN_LONG    = 3'd4
  } btn_evt_state_t;

  // Larger of two unsigned values, for elaboration-time sizing.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_decoder.sv
//------------------------------------------------------------------------------
// Module  : button_event_decoder
// Purpose : Turns a debounced, clock-synchronous button level into single-cycle
//           press / release / long-press / auto-repeat pulses and a held level.
//           All outputs are registered.
// Ports   : i_clk        - system clock, rising edge
//           i_rst_n      - asynchronous active-low reset
//           i_btn        - debounced button level, 1 = pressed
//           o_press      - one-cycle pulse on a press
//           o_release    - one-cycle pulse on a release
//           o_long_press - one-cycle pulse when the hold reaches LONG_PRESS_CYCLES
//           o_repeat     - one-cycle pulse every REPEAT_CYCLES after long press
//           o_held       - high while the button is considered pressed
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,  // must be >= 2
  parameter int unsigned REPEAT_CYCLES     = 10_000_000   // 0 disables repeat
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_held
);

  localparam int unsigned c_CNT_W = $clog2(max_u(LONG_PRESS_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_LONG = c_CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_REP  = c_CNT_W'(REPEAT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT  = {c_CNT_W{1'b1}};
  localparam logic               c_REP_EN   = (REPEAT_CYCLES != 0);

  btn_evt_state_t     r_state;
  btn_evt_state_t     w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  logic r_press;
  logic r_release;
  logic r_long_press;
  logic r_repeat;
  logic r_held;

  logic w_press_nxt;
  logic w_release_nxt;
  logic w_long_press_nxt;
  logic w_repeat_nxt;
  logic w_held_nxt;

  // Counter hits, qualified by the state that uses them.
  logic w_long_hit;
  logic w_rep_hit;

  assign w_long_hit = (r_state == BTN_PRESSED) && i_btn && (r_cnt == c_CNT_LONG);
  assign w_rep_hit  = c_REP_EN && (r_state == BTN_LONG) && i_btn && (r_cnt == c_CNT_REP);

  //--------------------------------------------------------------------------
  // State, counter and output registers
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= BTN_INIT;
      r_cnt        <= '0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_long_press <= 1'b0;
      r_repeat     <= 1'b0;
      r_held       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_press      <= w_press_nxt;
      r_release    <= w_release_nxt;
      r_long_press <= w_long_press_nxt;
      r_repeat     <= w_repeat_nxt;
      r_held       <= w_held_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state and counter
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      BTN_INIT: begin
        w_state_nxt = i_btn ? BTN_LOCKOUT : BTN_IDLE;
        w_cnt_nxt   = '0;
      end
      BTN_LOCKOUT: begin
        if (!i_btn) begin
          w_state_nxt = BTN_IDLE;
        end
        w_cnt_nxt = '0;
      end
      BTN_IDLE: begin
        if (i_btn) begin
          w_state_nxt = BTN_PRESSED;
          w_cnt_nxt   = c_CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      BTN_PRESSED: begin
        // Release is tested first so it wins over a long press due this edge.
        if (!i_btn) begin
          w_state_nxt = BTN_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_LONG) begin
          w_state_nxt = BTN_LONG;
          w_cnt_nxt   = c_CNT_ONE;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      BTN_LONG: begin
        if (!i_btn) begin
          w_state_nxt = BTN_IDLE;
          w_cnt_nxt   = '0;
        end else if (c_REP_EN && (r_cnt == c_CNT_REP)) begin
          w_cnt_nxt   = c_CNT_ONE;
        end else if (r_cnt != c_CNT_SAT) begin
          // With repeat disabled the hold can last forever; stop at all-ones
          // rather than wrapping.
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = BTN_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Output decode (values registered on the same edge as the state)
  //--------------------------------------------------------------------------
  always_comb begin
    w_press_nxt      = 1'b0;
    w_release_nxt    = 1'b0;
    w_long_press_nxt = 1'b0;
    w_repeat_nxt     = 1'b0;
    w_held_nxt       = 1'b0;
    case (r_state)
      BTN_IDLE: begin
        w_press_nxt = i_btn;
        w_held_nxt  = i_btn;
      end
      BTN_PRESSED, BTN_LONG: begin
        w_release_nxt    = !i_btn;
        w_held_nxt       = i_btn;
        w_long_press_nxt = w_long_hit;
        w_repeat_nxt     = w_rep_hit;
      end
      default: begin
        w_press_nxt = 1'b0;
      end
    endcase
  end

  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long_press;
  assign o_repeat     = r_repeat;
  assign o_held       = r_held;

endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
//------------------------------------------------------------------------------
// Module  : tb_button_event_decoder
// Purpose : Directed self-checking bench for button_event_decoder.
//           dut_a: LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4
//           dut_b: LONG_PRESS_CYCLES=8, REPEAT_CYCLES=0
//           Both share clock, reset and button input.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_event_decoder;
  import button_event_decoder_pkg::*;

  logic clk;
  logic rst_n;
  logic btn;

  logic a_press, a_release, a_long, a_rep, a_held;
  logic b_press, b_release, b_long, b_rep, b_held;

  int checks;
  int failures;

  // Per-cycle capture: bit i = output after edge E0+i.
  logic [63:0] cap_press, cap_release, cap_long, cap_rep, cap_held;
  logic [63:0] cap_b_long, cap_b_rep;

  button_event_decoder #(.LONG_PRESS_CYCLES(8), .REPEAT_CYCLES(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_press(a_press), .o_release(a_release), .o_long_press(a_long),
    .o_repeat(a_rep), .o_held(a_held)
  );

  button_event_decoder #(.LONG_PRESS_CYCLES(8), .REPEAT_CYCLES(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_press(b_press), .o_release(b_release), .o_long_press(b_long),
    .o_repeat(b_rep), .o_held(b_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive btn=1 for the first n_high edges, 0 for the rest, and log outputs.
  task automatic capture(input int n_high, input int n_total);
    cap_press = '0; cap_release = '0; cap_long = '0; cap_rep = '0; cap_held = '0;
    cap_b_long = '0; cap_b_rep = '0;
    for (int i = 0; i < n_total; i++) begin
      btn = (i < n_high);
      tick();
      cap_press[i]   = a_press;
      cap_release[i] = a_release;
      cap_long[i]    = a_long;
      cap_rep[i]     = a_rep;
      cap_held[i]    = a_held;
      cap_b_long[i]  = b_long;
      cap_b_rep[i]   = b_rep;
    end
  endtask

  task automatic test_reset();
    btn   = 1'b0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_press, a_release, a_long, a_rep, a_held} !== 5'b0) begin
      failures++;
      $display("FAIL reset_async_outputs: got %b need 00000", {a_press, a_release, a_long, a_rep, a_held});
    end
    tick();
    tick();
    checks++;
    if (dut_a.r_state !== BTN_INIT || dut_a.r_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d cnt=%0d need state=0 cnt=0", dut_a.r_state, dut_a.r_cnt);
    end
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (dut_a.r_state !== BTN_IDLE) begin
      failures++;
      $display("FAIL init_to_idle: got state=%0d need %0d", dut_a.r_state, BTN_IDLE);
    end
    checks++;
    if ({a_press, a_release, a_long, a_rep, a_held} !== 5'b0) begin
      failures++;
      $display("FAIL init_no_pulse: got %b need 00000", {a_press, a_release, a_long, a_rep, a_held});
    end
  endtask

  task automatic test_short_press();
    capture(3, 6);
    checks++;
    if (cap_press !== 64'h1) begin
      failures++; $display("FAIL short_press: got %h need %h", cap_press, 64'h1);
    end
    checks++;
    if (cap_held !== 64'h7) begin
      failures++; $display("FAIL short_held: got %h need %h", cap_held, 64'h7);
    end
    checks++;
    if (cap_release !== 64'h8) begin
      failures++; $display("FAIL short_release: got %h need %h", cap_release, 64'h8);
    end
    checks++;
    if ((cap_long | cap_rep) !== 64'h0) begin
      failures++; $display("FAIL short_no_long: got long=%h rep=%h need 0", cap_long, cap_rep);
    end
  endtask

  task automatic test_long_repeat();
    capture(20, 23);
    checks++;
    if (cap_press !== 64'h1) begin
      failures++; $display("FAIL lr_press: got %h need %h", cap_press, 64'h1);
    end
    checks++;
    if (cap_long !== 64'h100) begin
      failures++; $display("FAIL lr_long_press: got %h need %h", cap_long, 64'h100);
    end
    checks++;
    if (cap_rep !== 64'h11000) begin
      failures++; $display("FAIL lr_repeat: got %h need %h", cap_rep, 64'h11000);
    end
    checks++;
    if (cap_release !== 64'h100000) begin
      failures++; $display("FAIL lr_release: got %h need %h", cap_release, 64'h100000);
    end
    checks++;
    if (cap_held !== 64'hFFFFF) begin
      failures++; $display("FAIL lr_held: got %h need %h", cap_held, 64'hFFFFF);
    end
    checks++;
    if (cap_b_long !== 64'h100 || cap_b_rep !== 64'h0) begin
      failures++; $display("FAIL lr_norepeat_inst: got long=%h rep=%h need 100/0", cap_b_long, cap_b_rep);
    end
  endtask

  task automatic test_release_at_long_edge();
    capture(8, 11);
    checks++;
    if (cap_release !== 64'h100) begin
      failures++; $display("FAIL edge_release: got %h need %h", cap_release, 64'h100);
    end
    checks++;
    if (cap_long !== 64'h0 || cap_rep !== 64'h0) begin
      failures++; $display("FAIL edge_long_suppressed: got long=%h rep=%h need 0", cap_long, cap_rep);
    end
    checks++;
    if (cap_held !== 64'hFF) begin
      failures++; $display("FAIL edge_held: got %h need %h", cap_held, 64'hFF);
    end
  endtask

  task automatic test_lockout();
    btn = 1'b1;
    #2;
    rst_n = 1'b0;
    tick();
    #2;
    rst_n = 1'b1;
    capture(10, 12);
    checks++;
    if ((cap_press | cap_release | cap_long | cap_rep | cap_held) !== 64'h0) begin
      failures++;
      $display("FAIL lockout_silent: got press=%h rel=%h held=%h need 0", cap_press, cap_release, cap_held);
    end
    checks++;
    if (dut_a.r_state !== BTN_IDLE) begin
      failures++; $display("FAIL lockout_exit: got state=%0d need %0d", dut_a.r_state, BTN_IDLE);
    end
    capture(3, 5);
    checks++;
    if (cap_press !== 64'h1 || cap_release !== 64'h8 || cap_held !== 64'h7) begin
      failures++;
      $display("FAIL lockout_second_rise: got press=%h rel=%h held=%h need 1/8/7", cap_press, cap_release, cap_held);
    end
  endtask

  task automatic test_reset_mid_long();
    btn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (dut_a.r_state !== BTN_LONG || a_held !== 1'b1) begin
      failures++; $display("FAIL midrst_in_long: got state=%0d held=%b need %0d/1", dut_a.r_state, a_held, BTN_LONG);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_press, a_release, a_long, a_rep, a_held} !== 5'b0) begin
      failures++; $display("FAIL midrst_async_drop: got %b need 00000", {a_press, a_release, a_long, a_rep, a_held});
    end
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (dut_a.r_state !== BTN_LOCKOUT || a_held !== 1'b0) begin
      failures++; $display("FAIL midrst_lockout: got state=%0d held=%b need %0d/0", dut_a.r_state, a_held, BTN_LOCKOUT);
    end
    capture(4, 6);
    checks++;
    if ((cap_press | cap_release | cap_long | cap_rep | cap_held) !== 64'h0) begin
      failures++; $display("FAIL midrst_no_release: got press=%h rel=%h need 0", cap_press, cap_release);
    end
  endtask

  task automatic test_repeat_disabled();
    int n_long;
    int n_rep;
    n_long = 0;
    n_rep  = 0;
    btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_long += int'(b_long);
      n_rep  += int'(b_rep);
    end
    checks++;
    if (n_long != 1) begin
      failures++; $display("FAIL norep_long_count: got %0d need 1", n_long);
    end
    checks++;
    if (n_rep != 0) begin
      failures++; $display("FAIL norep_repeat_count: got %0d need 0", n_rep);
    end
    checks++;
    if (dut_b.r_cnt !== 4'hF || b_held !== 1'b1) begin
      failures++; $display("FAIL norep_saturate: got cnt=%0d held=%b need 15/1", dut_b.r_cnt, b_held);
    end
    btn = 1'b0;
    tick();
    checks++;
    if (b_release !== 1'b1 || b_held !== 1'b0) begin
      failures++; $display("FAIL norep_release: got rel=%b held=%b need 1/0", b_release, b_held);
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    btn      = 1'b0;
    rst_n    = 1'b1;
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_at_long_edge();
    test_lockout();
    test_reset_mid_long();
    test_repeat_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_event_decoder.md
# button_event_decoder

Converts the clean, debounced, clock-synchronous level of one pushbutton into single-cycle event pulses (press, release, long-press, auto-repeat) plus a held level. It sits directly downstream of the per-button synchronizer/debouncer in the FPGA I/O front end and feeds control FSMs that want discrete events rather than levels. It is purely synchronous to `Clk`. There is no metastability handling here: `btn` is already synchronized.

## Interface
- `LONG_PRESS_CYCLES`, default 50_000_000: number of held cycles from the press pulse to the long_press pulse. Must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: period of repeat pulses after long_press. A value of 0 disables repeat.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `btn`  in  1  debounced button level, 1 = pressed, synchronous to `Clk`.
- `press`  out  1  one-cycle pulse on a press.
- `release`  out  1  one-cycle pulse on a release.
- `long_press`  out  1  one-cycle pulse when the hold reaches `LONG_PRESS_CYCLES`.
- `repeat`  out  1  one-cycle pulse every `REPEAT_CYCLES` after long_press.
- `held`  out  1  level, high while the decoder considers the button pressed.

## Operation
- All outputs are registered. While `Reset_n` = 0, every output is 0, the state is INIT, and the counter is 0.
- Hold counter width is `$clog2(max(LONG_PRESS_CYCLES, REPEAT_CYCLES)+1)`.
- **INIT** (first edge after reset deasserts):
  - `btn`=1 → LOCKOUT.
  - `btn`=0 → IDLE.
  - No pulses are emitted from INIT.
- **LOCKOUT** (button already down at reset):
  - All outputs stay 0.
  - `btn`=0 → IDLE, with no release pulse.
- **IDLE**:
  - `btn`=1 → PRESSED, assert `press` and `held`, counter ← 1.
- **PRESSED**:
  - `btn`=0 → IDLE, assert `release`, clear `held` and the counter.
  - Otherwise, if counter = `LONG_PRESS_CYCLES` → LONG, assert `long_press`, counter ← 1.
  - Otherwise, counter increments.
- **LONG**:
  - `btn`=0 → IDLE, assert `release`, clear `held` and the counter.
  - Otherwise, if `REPEAT_CYCLES` ≠ 0 and counter = `REPEAT_CYCLES`: assert `repeat`, counter ← 1.
  - Otherwise, counter increments, saturating when `REPEAT_CYCLES` = 0.
- Priority: release beats long_press and repeat in the same cycle. At most one of press/release/long_press/repeat is high in any cycle.
- Counter never wraps past its maximum; the saturating hold in LONG with repeat disabled is required.

## Timing
- Let E0 be the first edge that samples `btn`=1 while in IDLE.
- `press`=1 and `held`=1 are visible after E0, during cycle E0→E1. `press` lasts exactly one cycle.
- `long_press` is high in the cycle after edge E0+`LONG_PRESS_CYCLES`, if `btn` was sampled 1 on every edge E0..E0+`LONG_PRESS_CYCLES`.
- `repeat` is high after edges E0+`LONG_PRESS_CYCLES`+k·`REPEAT_CYCLES`, k ≥ 1.
- Let F0 be the first edge sampling `btn`=0 in PRESSED/LONG:
  - `release`=1 and `held`=0 are visible after F0.
  - Any long_press/repeat due at F0 is suppressed.
- Press latency and release latency are each 1 cycle.
- `btn` high for a single cycle yields a press pulse followed immediately by a release pulse (back-to-back cycles). This is legal.
- `Reset_n` asserted mid-hold: outputs drop asynchronously, no release pulse is emitted, and the block re-enters via INIT (LOCKOUT if still held).

## Structure
- State enum `btn_evt_state_t` (INIT, IDLE, PRESSED, LOCKOUT, LONG) lives in the shared I/O package alongside the debouncer counter-width constant.
- Single module, no sub-module.
- The parent instantiates one sync_debounce plus one button_event_decoder per button.
- Benches override both parameters with small values.

## Test plan
All scenarios use `LONG_PRESS_CYCLES`=8, `REPEAT_CYCLES`=4.
- Reset with `btn`=0, then `btn`=1 for 3 cycles → press at cycle 1, held for 3 cycles, release 1 cycle after the fall, no long_press.
- `btn`=1 for 20 cycles from E0 → press at E0+1; long_press at E0+9; repeat at E0+13 and E0+17; release at the fall +1; exactly 1 long_press and 2 repeats.
- `btn` falls so that the first 0 sample coincides with edge E0+8 → release asserted, long_press never asserted.
- `btn`=1 held through reset release for 10 cycles, then 0, then 1 → no pulses until the second rise; the second rise gives a normal press.
- `Reset_n` pulsed low mid-LONG → all outputs 0 immediately, no release pulse, re-entry through LOCKOUT.
- `REPEAT_CYCLES`=0, `btn` held 40 cycles → exactly one long_press, zero repeats, counter saturates without wrap.
